sfx_player: RTL

- Multi-sound effect generator for the game audio path; successor to the single-effect jump sound block.
- Plays one of NUM_SOUNDS effects (jump, score, die), each a fixed-period PWM envelope whose duty decays geometrically per stage, optionally gated by a square-wave tone.
- Adds priority arbitration, retrigger, mute, busy/done status and parametrised timing.
- Drives the 1-bit speaker pin directly.

---
 rtl/sfx_pkg.sv | 56 +++++
 rtl/sfx_envelope.sv | 70 +++++++
 rtl/sfx_player.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared state type, effect ids, per-effect tone/sweep tables and the
// duty decay helper used by sfx_player and sfx_envelope.
// Optional feature macro: SFX_SWEEP_EN (adds the per-effect pitch sweep table).
package sfx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } sfx_state_t;

   typedef logic [1:0] sfx_id_t;

   localparam sfx_id_t SFX_JUMP  = 2'd0;
   localparam sfx_id_t SFX_SCORE = 2'd1;
   localparam sfx_id_t SFX_DIE   = 2'd2;

   localparam int NUM_TABLE = 3;

   // Tone half-period multiplier per effect; 0 means pure envelope.
   localparam int unsigned TONE_MULT [NUM_TABLE] = '{0, 1, 4};

`ifdef SFX_SWEEP_EN
   // Effects whose tone falls in pitch at every stage wrap.
   localparam bit SWEEP [NUM_TABLE] = '{1'b0, 1'b0, 1'b1};

   function automatic bit sweep_en(input sfx_id_t id);
      case (id)
         SFX_JUMP:  return SWEEP[0];
         SFX_SCORE: return SWEEP[1];
         SFX_DIE:   return SWEEP[2];
         default:   return 1'b0;
      endcase
   endfunction
`endif

   function automatic int unsigned tone_mult(input sfx_id_t id);
      case (id)
         SFX_JUMP:  return TONE_MULT[0];
         SFX_SCORE: return TONE_MULT[1];
         SFX_DIE:   return TONE_MULT[2];
         default:   return 0;
      endcase
   endfunction

   // Geometric decay with a floor; subtracting a right-shifted copy of itself
   // can never underflow, so the result only needs the floor clamp.
   function automatic logic [31:0] next_duty(input logic [31:0] duty,
                                             input int unsigned shift,
                                             input logic [31:0] floor_v);
      logic [31:0] d;
      d = duty - (duty >> shift);
      return (d < floor_v) ? floor_v : d;
   endfunction

endpackage

// File: rtl/sfx_envelope.sv
// sfx_envelope: stage counter, stage index and decaying duty register of the
// sound effect envelope. env is high while the counter is below the duty.
module sfx_envelope
   import sfx_pkg::*;
#(
   parameter int PERIOD      = 333333,
   parameter int CNT_W       = 19,
   parameter int NUM_STAGES  = 31,
   parameter int DECAY_SHIFT = 3,
   parameter int MIN_DUTY    = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic env,
   output logic stage_wrap,
   output logic last_wrap
);

   localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0]   DUTY_INIT  = CNT_W'(PERIOD >> 1);
   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

   logic [CNT_W-1:0]   counter_q, counter_d;
   logic [CNT_W-1:0]   duty_q, duty_d;
   logic [STAGE_W-1:0] stage_q, stage_d;

   // Envelope level and wrap strobes from the current counter/stage.
   always_comb begin
      env        = (counter_q < duty_q);
      stage_wrap = run && (counter_q == CNT_LAST);
      last_wrap  = stage_wrap && (stage_q == STAGE_LAST);
   end

   // Next state: restart wins, otherwise count and decay on every wrap.
   always_comb begin
      counter_d = counter_q;
      stage_d   = stage_q;
      duty_d    = duty_q;
      if (start) begin
         counter_d = '0;
         stage_d   = '0;
         duty_d    = DUTY_INIT;
      end else if (run) begin
         if (stage_wrap) begin
            counter_d = '0;
            stage_d   = stage_q + STAGE_W'(1);
            duty_d    = CNT_W'(next_duty(32'(duty_q), DECAY_SHIFT, 32'(MIN_DUTY)));
         end else begin
            counter_d = counter_q + CNT_W'(1);
         end
      end
   end

   // Envelope registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter_q <= '0;
         stage_q   <= '0;
         duty_q    <= '0;
      end else begin
         counter_q <= counter_d;
         stage_q   <= stage_d;
         duty_q    <= duty_d;
      end
   end

endmodule

// File: rtl/sfx_player.sv
// sfx_player: multi-effect PWM sound generator driving the speaker pin.
// Highest-index trigger wins; equal or higher priority retriggers restart.
// Optional feature macro: SFX_SWEEP_EN (falling-pitch sweep on selected effects).
module sfx_player
   import sfx_pkg::*;
#(
   parameter int PERIOD      = 333333,
   parameter int CNT_W       = 19,
   parameter int NUM_STAGES  = 31,
   parameter int DECAY_SHIFT = 3,
   parameter int MIN_DUTY    = 25,
   parameter int NUM_SOUNDS  = 3,
   parameter int TONE_BASE   = 25000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SOUNDS-1:0]  trigger,
   input  logic                   mute,
   output logic                   wave_out,
   output logic                   busy,
   output logic                   done,
   output logic [((NUM_SOUNDS > 1) ? $clog2(NUM_SOUNDS) : 1)-1:0] active_id
);

   localparam int ID_W = (NUM_SOUNDS > 1) ? $clog2(NUM_SOUNDS) : 1;

   sfx_state_t       state_q;
   logic             wave_q, busy_q, done_q;
   logic [ID_W-1:0]  active_id_q;
   logic [CNT_W-1:0] tone_half_q, tone_half_d;
   logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
   logic             tone_ph_q, tone_ph_d;

   logic [ID_W-1:0]  trig_id;
   logic             accept;
   logic [CNT_W-1:0] tone_start;
   logic             tone;
   logic             env, stage_wrap, last_wrap;

   sfx_envelope #(
      .PERIOD      (PERIOD),
      .CNT_W       (CNT_W),
      .NUM_STAGES  (NUM_STAGES),
      .DECAY_SHIFT (DECAY_SHIFT),
      .MIN_DUTY    (MIN_DUTY)
   ) u_env (
      .clk        (clk),
      .rst        (rst),
      .start      (accept),
      .run        (state_q == PLAY),
      .env        (env),
      .stage_wrap (stage_wrap),
      .last_wrap  (last_wrap)
   );

   // Priority select (highest index wins) and acceptance rule.
   always_comb begin
      trig_id = '0;
      for (int i = 0; i < NUM_SOUNDS; i++) begin
         if (trigger[i]) trig_id = ID_W'(i);
      end
      accept = (|trigger) && ((state_q != PLAY) || (trig_id >= active_id_q));
      tone_start = (32'(trig_id) < NUM_TABLE)
                   ? CNT_W'(TONE_BASE * tone_mult(sfx_id_t'(trig_id))) : '0;
   end

   // Tone generator: square wave of half-period tone_half, optional sweep.
   always_comb begin
      tone        = (tone_half_q == '0) || tone_ph_q;
      tone_cnt_d  = tone_cnt_q;
      tone_ph_d   = tone_ph_q;
      tone_half_d = tone_half_q;
      if (tone_half_q != '0) begin
         if (tone_cnt_q >= tone_half_q - CNT_W'(1)) begin
            tone_cnt_d = '0;
            tone_ph_d  = ~tone_ph_q;
         end else begin
            tone_cnt_d = tone_cnt_q + CNT_W'(1);
         end
      end
`ifdef SFX_SWEEP_EN
      if (stage_wrap && (32'(active_id_q) < NUM_TABLE) && sweep_en(sfx_id_t'(active_id_q))) begin
         logic [CNT_W:0] sweep_sum;
         sweep_sum   = (CNT_W+1)'(tone_half_q) + (CNT_W+1)'(tone_half_q >> 4);
         tone_half_d = sweep_sum[CNT_W] ? '1 : sweep_sum[CNT_W-1:0];
      end
`endif
   end

   // Player FSM with registered speaker, status and tone state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wave_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         active_id_q <= '0;
         tone_half_q <= '0;
         tone_cnt_q  <= '0;
         tone_ph_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // Speaker is silent on start/restart edges and on the completing wrap.
         wave_q <= (state_q == PLAY) && !accept && !last_wrap && env && tone && !mute;
         if (accept) begin
            state_q     <= PLAY;
            busy_q      <= 1'b1;
            active_id_q <= trig_id;
            tone_half_q <= tone_start;
            tone_cnt_q  <= '0;
            tone_ph_q   <= 1'b1;
         end else begin
            case (state_q)
               PLAY: begin
                  tone_cnt_q  <= tone_cnt_d;
                  tone_ph_q   <= tone_ph_d;
                  tone_half_q <= tone_half_d;
                  if (last_wrap) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign wave_out  = wave_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign active_id = active_id_q;

endmodule
